rng_requester: RTL and testbench

RNG_REQUESTER -- requirements
Module: rng_requester

---
 rtl/rng_pkg.sv | 28 ++
 rtl/rng_requester_if.sv | 27 ++
 rtl/btn_debounce.sv | 71 +++++++
 rtl/rng_requester.sv | 87 ++++++++
 tb/tb_rng_requester.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/rng_pkg.sv
// Shared types and constants for the RNG requester: FSM states, widths, BCD helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rng_pkg;

  localparam int BCD_W     = 4;
  localparam int VALUE_W   = 14;
  localparam int VALUE_MAX = 9999;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_CONV = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // One Horner step of BCD-to-binary: acc*10 + digit, fits in VALUE_W for valid BCD.
  function automatic logic [VALUE_W-1:0] mac10(input logic [VALUE_W-1:0] acc,
                                               input logic [BCD_W-1:0]   digit);
    return (acc * VALUE_W'(10)) + VALUE_W'(digit);
  endfunction

  function automatic logic bcd_bad(input logic [BCD_W-1:0] digit);
    return digit > BCD_W'(9);
  endfunction

endpackage

// File: rtl/rng_requester_if.sv
// Generator-side bus of the RNG requester: BCD digits in, request pulse and result out.
// Latency: n/a (wiring only).
// Backpressure: none; request is a fire-and-forget pulse, digits sampled at a fixed delay.
interface rng_requester_if;
  import rng_pkg::*;

  logic [BCD_W-1:0]   D1000;
  logic [BCD_W-1:0]   D100;
  logic [BCD_W-1:0]   D10;
  logic [BCD_W-1:0]   D1;
  logic               fetch_request;
  logic [VALUE_W-1:0] value;
  logic               value_valid;
  logic               bcd_error;
  logic               busy;

  modport master (
    input  D1000, D100, D10, D1,
    output fetch_request, value, value_valid, bcd_error, busy
  );

  modport slave (
    output D1000, D100, D10, D1,
    input  fetch_request, value, value_valid, bcd_error, busy
  );

endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop sync, optional debounce (RNG_REQ_DEBOUNCE_EN), rising-edge trigger.
// Latency: 2 sync cycles (+DEBOUNCE_CYCLES when debounce is enabled) to the trigger pulse.
// Backpressure: none; trigger is a one-cycle pulse, consumer drops it if not ready.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic trigger
);

  logic       sync1, sync2;
  logic       filt, filt_q;
  logic       armed;
  logic [1:0] vld;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Marks when sync2 reflects the real pin rather than reset zeros.
  always_ff @(posedge clk) begin
    if (rst) vld <= 2'b00;
    else     vld <= {vld[0], 1'b1};
  end

  // Arm only after the button has been seen released, so a press held through reset is ignored.
  always_ff @(posedge clk) begin
    if (rst)                     armed <= 1'b0;
    else if (vld[1] && !sync2)   armed <= 1'b1;
  end

`ifdef RNG_REQ_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [CNT_W-1:0] cnt;

  // Flip the filtered level after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (sync2 == filt) begin
      cnt  <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      filt <= sync2;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end
`else
  assign filt = sync2;
`endif

  // Previous filtered level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) filt_q <= 1'b0;
    else     filt_q <= filt;
  end

  assign trigger = filt & ~filt_q & armed;

endmodule

// File: rtl/rng_requester.sv
// Requests a 4-digit BCD number on a button press and converts it to binary (debounce: RNG_REQ_DEBOUNCE_EN).
// Latency: fetch_request 1 cycle after trigger; value_valid / bcd_error at F+CAPTURE_DELAY+5 / +1.
// Backpressure: none; triggers arriving while busy are dropped, never queued.
module rng_requester
  import rng_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CAPTURE_DELAY   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_in,
  rng_requester_if.master bus
);

  state_e                  state;
  logic [3:0]              cnt;
  logic [3:0][BCD_W-1:0]   dig;
  logic [VALUE_W-1:0]      acc;
  logic [VALUE_W-1:0]      acc_next;
  logic                    trigger;
  logic                    any_bad;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .trigger (trigger)
  );

  assign any_bad  = bcd_bad(bus.D1000) | bcd_bad(bus.D100) | bcd_bad(bus.D10) | bcd_bad(bus.D1);
  assign acc_next = mac10(acc, dig[cnt[1:0]]);

  // Request / wait / capture / convert sequencer; digits are only looked at on the capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      dig             <= '0;
      acc             <= '0;
      bus.value       <= '0;
      bus.value_valid <= 1'b0;
      bus.bcd_error   <= 1'b0;
    end else begin
      bus.value_valid <= 1'b0;
      bus.bcd_error   <= 1'b0;
      case (state)
        ST_IDLE: if (trigger) state <= ST_REQ;
        ST_REQ: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == 4'(CAPTURE_DELAY - 1)) begin
            dig <= {bus.D1, bus.D10, bus.D100, bus.D1000};
            acc <= '0;
            cnt <= '0;
            if (any_bad) begin
              bus.bcd_error <= 1'b1;
              state         <= ST_DONE;
            end else begin
              state         <= ST_CONV;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_CONV: begin
          acc <= acc_next;
          if (cnt == 4'd3) begin
            bus.value       <= acc_next;
            bus.value_valid <= 1'b1;
            state           <= ST_DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.fetch_request = (state == ST_REQ);
  assign bus.busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_rng_requester.sv
// Directed bench for rng_requester: press sequences, BCD digits, error, drop and reset cases.
// Latency: expected pulse timing is measured relative to the observed fetch_request cycle.
// Backpressure: n/a.
module tb_rng_requester;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;

  rng_requester_if bus ();

  rng_requester #(.DEBOUNCE_CYCLES(16), .CAPTURE_DELAY(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Event monitor, sampled on the falling edge.
  int cyc = 0;
  int n_fetch = 0, n_vv = 0, n_err = 0;
  int f_cyc = 0, vv_cyc = 0, err_cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (bus.fetch_request) begin n_fetch++; f_cyc = cyc; end
    if (bus.value_valid)   begin n_vv++;    vv_cyc = cyc; end
    if (bus.bcd_error)     begin n_err++;   err_cyc = cyc; end
  end

  int nf0, nv0, ne0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    nf0 = n_fetch; nv0 = n_vv; ne0 = n_err;
  endtask

  task automatic set_dig(input logic [15:0] d);
    bus.D1000 = d[15:12];
    bus.D100  = d[11:8];
    bus.D10   = d[7:4];
    bus.D1    = d[3:0];
  endtask

  task automatic wait_fetch(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.fetch_request) begin ok = 1'b1; break; end
    end
    chk({tag, "_fetch_seen"}, int'(ok), 1);
  endtask

  // Press, present rd only in the capture cycle F+2 (jd otherwise), release, settle.
  task automatic do_op(input string tag, input logic [15:0] rd, input logic [15:0] jd,
                       input bit repress);
    set_dig(jd);
    btn_in = 1'b1;
    wait_fetch(tag);
    if (repress) btn_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    set_dig(rd);
    if (repress) btn_in = 1'b1;
    @(negedge clk);
    set_dig(jd);
    repeat (20) @(negedge clk);
    btn_in = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 1'b0;
    set_dig(16'h0000);
    repeat (3) @(negedge clk);
    chk("rst_fetch", int'(bus.fetch_request), 0);
    chk("rst_value", int'(bus.value), 0);
    chk("rst_vv",    int'(bus.value_valid), 0);
    chk("rst_err",   int'(bus.bcd_error), 0);
    chk("rst_busy",  int'(bus.busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic press: 1234.
    snap();
    do_op("op1234", 16'h1234, 16'h1234, 1'b0);
    chk("op1234_nfetch", n_fetch - nf0, 1);
    chk("op1234_nvv",    n_vv - nv0, 1);
    chk("op1234_lat",    vv_cyc - f_cyc, 7);
    chk("op1234_value",  int'(bus.value), 1234);
    chk("op1234_nerr",   n_err - ne0, 0);

    // Bouncing button: toggles every 3 cycles for 30 cycles.
    set_dig(16'h1234);
    snap();
    for (int i = 0; i < 10; i++) begin
      btn_in = ~btn_in;
      if (i == 0) btn_in = 1'b1;
      repeat (3) @(negedge clk);
    end
    btn_in = 1'b0;
    repeat (40) @(negedge clk);
`ifdef RNG_REQ_DEBOUNCE_EN
    chk("bounce_nfetch", n_fetch - nf0, 0);
`else
    chk("bounce_fetched", int'((n_fetch - nf0) != 0), 1);
`endif

    // Invalid tens digit at the capture edge only.
    snap();
    do_op("bcderr", 16'h12C4, 16'h5678, 1'b0);
    chk("bcderr_nerr",  n_err - ne0, 1);
    chk("bcderr_lat",   err_cyc - f_cyc, 3);
    chk("bcderr_nvv",   n_vv - nv0, 0);
    chk("bcderr_value", int'(bus.value), 1234);

    // Extremes.
    snap();
    do_op("op9999", 16'h9999, 16'h5555, 1'b0);
    chk("op9999_value", int'(bus.value), 9999);
    chk("op9999_nvv",   n_vv - nv0, 1);

    snap();
    do_op("op0000", 16'h0000, 16'h3333, 1'b0);
    chk("op0000_value", int'(bus.value), 0);
    chk("op0000_nvv",   n_vv - nv0, 1);
    chk("op0000_lat",   vv_cyc - f_cyc, 7);

    // Second press while converting is dropped.
    snap();
    do_op("repress", 16'h4321, 16'h8765, 1'b1);
    chk("repress_nfetch", n_fetch - nf0, 1);
    chk("repress_nvv",    n_vv - nv0, 1);
    chk("repress_value",  int'(bus.value), 4321);

    // Reset during WAIT with the button held through reset release.
    set_dig(16'h1111);
    snap();
    btn_in = 1'b1;
    wait_fetch("rstwait");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstwait_busy",  int'(bus.busy), 0);
    chk("rstwait_fetch", int'(bus.fetch_request), 0);
    chk("rstwait_value", int'(bus.value), 0);
    chk("rstwait_vv",    int'(bus.value_valid), 0);
    chk("rstwait_err",   int'(bus.bcd_error), 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("rstwait_nfetch", n_fetch - nf0, 1);
    chk("rstwait_nvv",    n_vv - nv0, 0);
    chk("rstwait_nerr",   n_err - ne0, 0);
    btn_in = 1'b0;
    repeat (40) @(negedge clk);

    snap();
    do_op("after_rst", 16'h2468, 16'h7777, 1'b0);
    chk("after_rst_nfetch", n_fetch - nf0, 1);
    chk("after_rst_value",  int'(bus.value), 2468);
    chk("after_rst_lat",    vv_cyc - f_cyc, 7);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
